// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operating-mode
// encodings used by the RTL and by anything that drives the mode port.
package usr_defs;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROTL = 3'b100;
    localparam logic [2:0] MODE_ROTR = 3'b101;
    localparam logic [2:0] MODE_ASHR = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

endpackage : usr_defs

// File: rtl/univ_shift_reg_dff_en_rst.sv
// Single-bit storage element with synchronous active-high reset to a
// per-bit reset value and a clock enable. Priority: rst, then en, else hold.
module dff_en_rst (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic r_q;

    // Register the bit: reset wins over enable; without enable the bit holds.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            r_q <= rst_val;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : dff_en_rst

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, load, logical shifts with serial
// inputs, rotates, arithmetic shift right and clear. The per-bit next-state
// mux lives here; storage is WIDTH instances of dff_en_rst.
module univ_shift_reg
    import usr_defs::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             zero
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;

    // Select the next register value from the current contents and mode.
    always_comb begin
        // NOTE: assign a default before the case so every path drives w_next;
        // an unassigned path in combinational logic infers a latch.
        w_next = w_q;
        case (mode)
            MODE_HOLD: w_next = w_q;
            MODE_LOAD: w_next = d;
            MODE_SHL:  w_next = {w_q[WIDTH-2:0], sin_r};
            MODE_SHR:  w_next = {sin_l, w_q[WIDTH-1:1]};
            MODE_ROTL: w_next = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
            MODE_ROTR: w_next = {w_q[0], w_q[WIDTH-1:1]};
            MODE_ASHR: w_next = {w_q[WIDTH-1], w_q[WIDTH-1:1]};
            MODE_CLR:  w_next = '0;
            default:   w_next = w_q;
        endcase
    end

    // One enable/reset flop per bit; reset value is taken bitwise from RESET_VAL.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_rst u_dff (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .rst_val (RESET_VAL[i]),
            .d       (w_next[i]),
            .q       (w_q[i])
        );
    end

    assign q      = w_q;
    assign sout_l = w_q[WIDTH-1];
    assign sout_r = w_q[0];
    assign zero   = (w_q == '0);

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5) with
// hand-computed expected values checked by immediate assertions.
module tb_univ_shift_reg;
    import usr_defs::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] q;
    logic         sout_l;
    logic         sout_r;
    logic         zero;

    int n_vec = 0;
    int n_err = 0;

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample 1 time unit later.
    task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                       input logic [W-1:0] dv, input logic sr, input logic sl);
        @(negedge clk);
        rst = r; en = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] rotl_exp [8];
    logic [W-1:0] ashr_exp [3];

    initial begin
        rotl_exp = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
        ashr_exp = '{8'hC0, 8'hE0, 8'hF0};
        rst = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; sin_r = 1'b0; sin_l = 1'b0;

        // Reset wins over en=1/LOAD.
        cyc(1'b1, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        check("reset_q", q, 8'hA5);
        check("reset_sout_l", {7'd0, sout_l}, 8'h01);
        check("reset_sout_r", {7'd0, sout_r}, 8'h01);
        check("reset_zero", {7'd0, zero}, 8'h00);

        // Load then shift left / right with serial inputs.
        cyc(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
        check("load_81", q, 8'h81);
        check("load_81_sout_l", {7'd0, sout_l}, 8'h01);
        cyc(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b1);
        check("shl_sin1", q, 8'h03);
        cyc(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b1, 1'b0);
        check("shr_sin0", q, 8'h01);

        // HOLD with en=1 keeps q.
        cyc(1'b0, 1'b1, MODE_HOLD, 8'hFF, 1'b1, 1'b1);
        check("hold_en1", q, 8'h01);

        // Rotate left 8 times, then right 8 times, back to start each time.
        cyc(1'b0, 1'b1, MODE_LOAD, 8'h96, 1'b0, 1'b0);
        check("load_96", q, 8'h96);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, MODE_ROTL, 8'h00, 1'b1, 1'b1);
            check($sformatf("rotl_%0d", i), q, rotl_exp[i]);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, MODE_ROTR, 8'h00, 1'b0, 1'b0);
            check($sformatf("rotr_%0d", i), q, (i == 7) ? 8'h96 : rotl_exp[6 - i]);
        end

        // Arithmetic shift right: negative fills with ones, sin_l ignored.
        cyc(1'b0, 1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, MODE_ASHR, 8'h00, 1'b0, 1'b0);
            check($sformatf("ashr_neg_%0d", i), q, ashr_exp[i]);
        end
        cyc(1'b0, 1'b1, MODE_LOAD, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, MODE_ASHR, 8'h00, 1'b1, 1'b1);
        check("ashr_pos_x7", q, 8'h00);
        check("ashr_pos_zero", {7'd0, zero}, 8'h01);

        // Enable low blocks CLR; CLR with enable gives 0, not RESET_VAL.
        cyc(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, MODE_CLR, 8'hFF, 1'b1, 1'b1);
            check($sformatf("en0_hold_%0d", i), q, 8'h3C);
        end
        cyc(1'b0, 1'b1, MODE_CLR, 8'hFF, 1'b1, 1'b1);
        check("clr_q", q, 8'h00);
        check("clr_zero", {7'd0, zero}, 8'h01);

        // Reset applies even with en=0.
        cyc(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0);
        check("reset_en0", q, 8'hA5);

        // Mid-stream reset during a run of SHL edges.
        cyc(1'b0, 1'b1, MODE_LOAD, 8'h0F, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        check("mid_shl_1", q, 8'h1F);
        cyc(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        check("mid_shl_2", q, 8'h3F);
        cyc(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0);
        check("mid_shl_rst", q, 8'hA5);
        cyc(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
        check("mid_shl_after", q, 8'h4A);

        // SHL x8 fully replaces with sin_r; SHR x8 fully replaces with sin_l.
        cyc(1'b0, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, MODE_SHL, 8'h00, 1'b0, 1'b1);
        check("shl_x8", q, 8'h00);
        check("shl_x8_zero", {7'd0, zero}, 8'h01);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
        check("shr_x8", q, 8'hFF);
        check("shr_x8_sout_r", {7'd0, sout_r}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_univ_shift_reg

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit DFF: a WIDTH-bit clocked register with enable, synchronous reset and eight operating modes.
- Modes are hold, parallel load, logical shift left/right with serial inputs, rotate left/right, arithmetic shift right and clear.
- Used as a general storage/shift element in later labs: serial-parallel converters, LFSR cores and accumulators.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 2.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  clock enable; when 0 the register holds (mode ignored).
- mode  input  3  operation select; encodings under Behaviour.
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering bit 0 on shift left.
- sin_l  input  1  serial input entering bit WIDTH-1 on shift right.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1] (combinational from q).
- sout_r  output  1  q[0] (combinational from q).
- zero  output  1  1 when q == 0 (combinational from q).

Behaviour:
- Single clock domain; q is the only state. It updates only at rising clk, with 1-cycle latency from inputs to q.
- Priority at each rising edge: rst, then en, then mode.
  - rst=1: q <= RESET_VAL regardless of en and mode. Mid-operation reset discards the shift in progress, with no partial update.
  - rst=0, en=0: q holds.
  - rst=0, en=1: q updates per mode, below.
- Mode encodings:
  - 000 HOLD: q <= q.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_r}.
  - 011 SHR: q <= {sin_l, q[WIDTH-1:1]}.
  - 100 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROTR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 ASHR: q <= {q[WIDTH-1], q[WIDTH-1:1]}. The sign bit is replicated; sin_l is ignored.
  - 111 CLR: q <= 0. This is distinct from reset: it honours en and always yields 0, not RESET_VAL.
- Serial inputs affect q only in SHL/SHR.
- sout_l/sout_r reflect the current q, i.e. the bit that the next SHL/SHR will shift out.
- Wrap-around: ROTL/ROTR repeated WIDTH times returns the original value. SHL/SHR repeated WIDTH times fully replaces q with serial input bits.
- ASHR on a negative value converges to all-ones; on a non-negative value it converges to 0.
- X/Z on mode with en=1 is a bench error; the RTL need not define the result.
- Power-up before the first reset is undefined. The bench must assert rst for >= 1 rising edge before checking.

Decomposition:
- Shared package/header (usr_defs): 3-bit localparam constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_ASHR, MODE_CLR.
- Sub-module dff_en_rst: 1-bit flip-flop with clk, rst, en, rst_val, d, q.
  - Implements the rst > en > hold priority.
  - Instantiated WIDTH times via generate.
  - The next-state mux per bit lives in univ_shift_reg.

Test Plan (WIDTH=8, RESET_VAL=8'hA5 unless noted):
- rst=1 for one edge with en=1, mode=LOAD, d=8'hFF -> q=8'hA5, sout_l=1, sout_r=1, zero=0.
- en=1, LOAD d=8'h81, then SHL with sin_r=1 -> q=8'h03 after one edge, sout_l of prior cycle was 1. Then SHR with sin_l=0 -> q=8'h01.
- LOAD 8'h96, then 8 consecutive ROTL edges -> q steps 8'h2D, 8'h5A, ... and equals 8'h96 after the 8th. 8 ROTR edges give the same return.
- LOAD 8'h80, then ASHR x3 -> 8'hC0, 8'hE0, 8'hF0. LOAD 8'h40, ASHR x7 -> q=8'h00, zero=1.
- LOAD 8'h3C, then en=0 with mode=CLR for 3 edges -> q stays 8'h3C. en=1, CLR -> q=8'h00 (not 8'hA5), zero=1.
- Mid-stream: 4 SHL edges in progress, rst=1 on the 3rd edge -> q=8'hA5 that edge; next SHL with sin_r=0 -> q=8'h4A.
